// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned WB_REGWRITE = 0;
    localparam int unsigned WB_MEMTOREG = 1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } mem_state_e;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of a loaded word and sign- or zero-extends it.
module load_extend
    import mips_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        unique case (offset_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

        data_o = word_i;
        if (size_i == SZ_BYTE) begin
            data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
        end else if (size_i == SZ_HALF) begin
            data_o = {{16{sign_i & half_sel[15]}}, half_sel};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack memory port, stalls until each access completes.
// Optional ack watchdog and mem_bus_err output enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
    import mips_mem_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  EX_WB,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic [1:0]  EX_MemSize,
    input  logic        EX_MemSign,
    input  logic [31:0] EX_ALUout,
    input  logic [31:0] EX_rt_data,
    input  logic [4:0]  EX_rd_or_rt,
    output logic [1:0]  MEM_WB,
    output logic [31:0] MEM_ALUout,
    output logic [31:0] MEM_MEMout,
    output logic [4:0]  MEM_rd_or_rt,
    output logic        mem_stall,
    output logic        mem_misalign,
`ifdef MEM_TIMEOUT_EN
    output logic        mem_bus_err,
`endif
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    mem_state_e  state_q, state_d;
    logic        memop, misalign, start;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, rdata_q, load_data;
    logic        timeout, bus_err;

    assign memop    = EX_MemRead | EX_MemWrite;
    assign misalign = memop &&
                      (((EX_MemSize == SZ_HALF) && EX_ALUout[0]) ||
                       (EX_MemSize[1] && (EX_ALUout[1:0] != 2'b00)));
    assign start    = (state_q == StIdle) && memop && !misalign;

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = EX_rt_data;
        if (EX_MemSize == SZ_BYTE) begin
            wdata_d = {4{EX_rt_data[7:0]}};
            if (!EX_MemRead) be_d = 4'b0001 << EX_ALUout[1:0];
        end else if (EX_MemSize == SZ_HALF) begin
            wdata_d = {2{EX_rt_data[15:0]}};
            if (!EX_MemRead) be_d = EX_ALUout[1] ? 4'b1100 : 4'b0011;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WdW-1:0] wd_q, wd_d;
    logic           err_q;

    assign timeout = (state_q == StBusy) && !dmem_ack &&
                     (wd_q == WdW'(TIMEOUT_CYCLES - 1));
    assign bus_err = (state_q == StDone) && err_q;
    assign mem_bus_err = bus_err;

    always_comb begin
        wd_d = wd_q;
        if (state_q != StBusy) begin
            wd_d = '0;
        end else if (!dmem_ack) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StBusy;
            StBusy:  if (dmem_ack || timeout) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request registers stay frozen while BUSY so the memory sees a stable request.
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            rdata_q    <= '0;
        end else begin
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= !EX_MemRead && EX_MemWrite;
                dmem_addr  <= {EX_ALUout[31:2], 2'b00};
                dmem_be    <= be_d;
                dmem_wdata <= wdata_d;
            end else if ((state_q == StBusy) && (dmem_ack || timeout)) begin
                dmem_req <= 1'b0;
            end
            if ((state_q == StBusy) && dmem_ack) rdata_q <= dmem_rdata;
        end
    end

    load_extend u_load_extend (
        .word_i   (rdata_q),
        .offset_i (EX_ALUout[1:0]),
        .size_i   (EX_MemSize),
        .sign_i   (EX_MemSign),
        .data_o   (load_data)
    );

    always_comb begin
        mem_stall    = start || (state_q == StBusy);
        mem_misalign = (state_q == StIdle) && misalign;
        MEM_ALUout   = EX_ALUout;
        MEM_rd_or_rt = EX_rd_or_rt;
        MEM_WB       = EX_WB;
        if (mem_misalign || bus_err) MEM_WB[WB_REGWRITE] = 1'b0;
        MEM_MEMout = '0;
        if ((state_q == StDone) && EX_MemRead && !bus_err) MEM_MEMout = load_data;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit of the 5-stage MIPS pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register, feeding MEM_WB, MEM_ALUout, MEM_MEMout and MEM_rd_or_rt.
- Performs byte, halfword and word loads/stores over a variable-latency req/ack data-memory port.
- Stalls the pipeline until each access completes; non-memory instructions pass through combinationally with no stall.

Parameters:
- TIMEOUT_CYCLES, 16: ack watchdog limit; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- EX_WB  in  2  D0 = RegWrite, D1 = MemToReg, from EX/MEM
- EX_MemRead  in  1  load instruction
- EX_MemWrite  in  1  store instruction
- EX_MemSize  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word
- EX_MemSign  in  1  1 = sign-extend load (lb/lh), 0 = zero-extend (lbu/lhu)
- EX_ALUout  in  32  effective address or ALU result
- EX_rt_data  in  32  store data
- EX_rd_or_rt  in  5  destination register
- MEM_WB  out  2  to MEM/WB
- MEM_ALUout  out  32  = EX_ALUout
- MEM_MEMout  out  32  extended load data
- MEM_rd_or_rt  out  5  = EX_rd_or_rt
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; inserts a bubble into MEM/WB
- mem_misalign  out  1  misaligned access detected
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  write enable
- dmem_addr  out  32  word address, {EX_ALUout[31:2], 2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  32  read data, valid with dmem_ack

Behaviour:
- Interface contract: clock is clk; reset is synchronous, active-high. All state updates on posedge clk.
- Reset:
  - state = IDLE; dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr = 0.
  - Captured load register = 0; watchdog = 0.
  - mem_stall and mem_misalign go low on the next edge.
- memop = EX_MemRead | EX_MemWrite. If both are set, the access is a read.
- Alignment: misaligned if (half and addr[0]) or (word and addr[1:0] != 0).
- Byte lanes are little-endian: byte lane k = bits [8k+7:8k] at addr[1:0] = k.
- Store byte enables:
  - byte: 1 << addr[1:0]
  - half: 0011 or 1100 selected by addr[1]
  - word: 1111
- Store data: byte {4{rt[7:0]}}, half {2{rt[15:0]}}, word rt. Load byte enables are always 1111.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, aligned memop: mem_stall = 1; latch addr, be, wdata and we into the dmem_* registers; dmem_req <= 1; go to BUSY.
  - IDLE, non-memop: mem_stall = 0; pass-through.
  - IDLE, misaligned memop: no request; mem_stall = 0; mem_misalign = 1 (combinational); MEM_WB[0] forced 0; store is suppressed; MEM_MEMout = 0.
  - BUSY: mem_stall = 1; dmem_req held with stable addr/be/wdata/we until dmem_ack.
  - BUSY, dmem_ack: capture dmem_rdata; dmem_req <= 0; go to DONE.
  - DONE: mem_stall = 0 for exactly one cycle. MEM/WB captures EX values plus MEM_MEMout; go to IDLE.
- MEM_MEMout is extracted from the captured word. Select the byte/half by addr[1:0] or addr[1], then sign- or zero-extend per EX_MemSign. It is 0 for stores and non-memops.
- Latency: minimum 3 cycles per access (IDLE, BUSY with same-cycle ack, DONE); an N-cycle ack delay gives N+2.
- Back-to-back memops: after DONE, IDLE re-evaluates the new EX inputs. No request is issued twice for the same instruction.
- dmem_ack outside BUSY is ignored.
- Reset mid-BUSY: the request is abandoned (dmem_req low next cycle); the memory controller must tolerate abandoned requests.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - Watchdog counter starts at 0 on entry to BUSY and increments each BUSY cycle without ack.
  - At TIMEOUT_CYCLES: drop dmem_req, go to DONE, MEM_MEMout = 0, MEM_WB[0] forced 0.
  - mem_bus_err output (1 bit) pulses for that DONE cycle.
- Not defined: no counter and no mem_bus_err port; BUSY waits indefinitely.

Decomposition:
- Shared package mips_mem_pkg:
  - MemSize encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - FSM state encodings
  - WB-bit index constants (WB_REGWRITE = 0, WB_MEMTOREG = 1)
- One natural sub-module, load_extend: combinational byte/half select plus sign/zero extension.

Test Plan:
- Non-memop, EX_ALUout = 0x0000_1234, EX_WB = 01 -> mem_stall = 0, MEM_ALUout = 0x1234, no dmem_req.
- sb, addr = 0x103, rt = 0xAABBCC5A, ack after 2 cycles -> dmem_addr = 0x100, be = 1000, wdata = 0x5A5A5A5A; mem_stall high for 4 cycles.
- lb/lbu/lh, addr = 0x102, rdata = 0x80F0_1234 ->
  - lb = 0xFFFF_FFF0
  - lbu = 0x0000_00F0
  - lh = 0xFFFF_80F0
- lw, addr = 0x202 -> mem_misalign = 1, no req, MEM_WB[0] = 0, no stall.
- Reset asserted in BUSY -> dmem_req = 0, state IDLE, mem_stall = 0 on the next cycle; a late ack is ignored.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and ack never given -> req drops after 4 cycles, mem_bus_err pulses, MEM_WB[0] = 0.
